btn_conditioner: RTL and testbench

- Front-end conditioning stage for the push-buttons and slide switches ahead of the bus-mapped IO register bank.
- Per channel, it synchronises the raw pad input, debounces it with a counter-qualified FSM, and produces three outputs: a clean level, a one-cycle press pulse and a one-cycle release pulse.
- The IO register bank consumes the pulses as sticky button flags and the levels as switch state.

---
 rtl/btn_cond_pkg.sv | 33 +++
 rtl/btn_channel.sv | 120 ++++++++++++
 rtl/btn_conditioner.sv | 34 +++
 tb/tb_btn_conditioner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared FSM encoding, default timing constants and width helpers for the button conditioner.
// Pure declarations: no latency and no backpressure apply.
package btn_cond_pkg;

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_RISE_CHK = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_FALL_CHK = 2'd3;

    // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 100 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One channel: 2-flop synchroniser, counter-qualified debounce FSM, registered press/release pulses.
// Level and pulse land DEBOUNCE_CYCLES+3 edges after a clean input edge; no backpressure (pulses are fire-and-forget).
module btn_channel
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = (clog2(CNT_MAX + 1) < 1) ? 1 : clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    logic [1:0]       r_sync;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_sync;
`ifdef BTN_REPEAT_EN
    logic [CNT_W-1:0] r_rcnt;
    logic             r_rphase;   // 0: waiting out the initial delay, 1: periodic repeats
`endif

    assign w_sync = r_sync[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= 2'b00;
            r_state   <= S_LOW;
            r_cnt     <= CNT_ZERO;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef BTN_REPEAT_EN
            r_rcnt    <= CNT_ZERO;
            r_rphase  <= 1'b0;
`endif
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (w_sync) begin
                        r_state <= S_RISE_CHK;
                        r_cnt   <= CNT_ZERO;
                    end
                end
                S_RISE_CHK: begin
                    if (!w_sync) begin
                        r_state <= S_LOW;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= S_HIGH;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
`ifdef BTN_REPEAT_EN
                        r_rcnt   <= CNT_ZERO;
                        r_rphase <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!w_sync) begin
                        r_state <= S_FALL_CHK;
                        r_cnt   <= CNT_ZERO;
`ifdef BTN_REPEAT_EN
                        r_rcnt   <= CNT_ZERO;
                        r_rphase <= 1'b0;
                    end else if (r_rcnt == (r_rphase ? RP_LAST : RD_LAST)) begin
                        r_press  <= 1'b1;
                        r_rcnt   <= CNT_ZERO;
                        r_rphase <= 1'b1;
                    end else begin
                        r_rcnt <= r_rcnt + CNT_ONE;
`endif
                    end
                end
                default: begin
                    if (w_sync) begin
                        r_state <= S_HIGH;
`ifdef BTN_REPEAT_EN
                        r_rcnt   <= CNT_ZERO;
                        r_rphase <= 1'b0;
`endif
                    end else if (r_cnt == DB_LAST) begin
                        r_state   <= S_LOW;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/btn_conditioner.sv
// NUM_CH independent debounce channels; define BTN_REPEAT_EN to add press auto-repeat while held.
// Latency DEBOUNCE_CYCLES+3 edges from a clean input edge; no backpressure, pulses last one cycle.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] BTN_IN,
    output logic [NUM_CH-1:0] DB_LEVEL,
    output logic [NUM_CH-1:0] PRESS_PULSE,
    output logic [NUM_CH-1:0] RELEASE_PULSE
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .i_clk     (CLK),
            .i_rst     (RESET),
            .i_btn     (BTN_IN[g]),
            .o_level   (DB_LEVEL[g]),
            .o_press   (PRESS_PULSE[g]),
            .o_release (RELEASE_PULSE[g])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed plus randomized bench for btn_conditioner against a run-length reference model.
module tb_btn_conditioner;

    localparam int NCH = 4;
    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
`ifdef BTN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic           CLK;
    logic           RESET;
    logic [NCH-1:0] BTN_IN;
    logic [NCH-1:0] DB_LEVEL;
    logic [NCH-1:0] PRESS_PULSE;
    logic [NCH-1:0] RELEASE_PULSE;

    btn_conditioner #(
        .NUM_CH          (NCH),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BTN_IN        (BTN_IN),
        .DB_LEVEL      (DB_LEVEL),
        .PRESS_PULSE   (PRESS_PULSE),
        .RELEASE_PULSE (RELEASE_PULSE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: input seen two edges late; a level is accepted once the
    // delayed input has disagreed with it for DB+1 consecutive edges.
    logic [NCH-1:0] hist[$];
    int             run[NCH];
    int             age[NCH];
    logic [NCH-1:0] m_lvl, m_press, m_rel;

    task automatic model_step();
        logic [NCH-1:0] s;
        if (RESET) begin
            hist = '{4'b0000, 4'b0000};
            for (int c = 0; c < NCH; c++) begin
                run[c] = 0;
                age[c] = 0;
            end
            m_lvl = '0; m_press = '0; m_rel = '0;
        end else begin
            s = hist.pop_front();
            hist.push_back(BTN_IN);
            m_press = '0; m_rel = '0;
            for (int c = 0; c < NCH; c++) begin
                if (s[c] != m_lvl[c]) begin
                    run[c] = run[c] + 1;
                    if (run[c] == DB + 1) begin
                        m_lvl[c] = s[c];
                        if (s[c]) m_press[c] = 1'b1;
                        else      m_rel[c]   = 1'b1;
                        run[c] = 0;
                        age[c] = 0;
                    end
                end else begin
                    if (m_lvl[c] && run[c] == 0) begin
                        age[c] = age[c] + 1;
                        if (REP_EN && (age[c] == RD || (age[c] > RD && (age[c] - RD) % RP == 0)))
                            m_press[c] = 1'b1;
                    end else if (m_lvl[c]) begin
                        age[c] = 0;
                    end
                    run[c] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        chk("db_level", DB_LEVEL, m_lvl);
        chk("press", PRESS_PULSE, m_press);
        chk("release", RELEASE_PULSE, m_rel);
        chk("press_and_release", PRESS_PULSE & RELEASE_PULSE, 4'b0000);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [NCH-1:0] b, input logic r);
        @(negedge CLK);
        BTN_IN = b;
        RESET  = r;
    endtask

    initial begin
        int             hold[NCH];
        int             act;
        int             npress;
        logic [NCH-1:0] v;

        BTN_IN = '0;
        RESET  = 1'b1;
        hist   = '{4'b0000, 4'b0000};
        ticks(3);
        chk("reset_level", DB_LEVEL, 4'b0000);
        chk("reset_press", PRESS_PULSE, 4'b0000);
        chk("reset_release", RELEASE_PULSE, 4'b0000);

        // Clean press on ch0: accepted on the 7th edge
        drive(4'b0000, 1'b0);
        ticks(2);
        drive(4'b0001, 1'b0);
        ticks(6);
        chk("press_edge6_level", DB_LEVEL, 4'b0000);
        tick();
        chk("press_edge7_level", DB_LEVEL, 4'b0001);
        chk("press_edge7_pulse", PRESS_PULSE, 4'b0001);
        tick();
        chk("press_edge8_pulse", PRESS_PULSE, 4'b0000);

        // Bounce on ch1: 1 high / 2 low never qualifies
        act = 0;
        for (int i = 0; i < 20; i++) begin
            v    = 4'b0001;
            v[1] = (i % 3 == 0);
            drive(v, 1'b0);
            tick();
            act += int'(DB_LEVEL[1]) + int'(PRESS_PULSE[1]) + int'(RELEASE_PULSE[1]);
        end
        drive(4'b0001, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            act += int'(DB_LEVEL[1]) + int'(PRESS_PULSE[1]) + int'(RELEASE_PULSE[1]);
        end
        chk_int("bounce_ch1_activity", act, 0);

        // Clean release on ch0
        drive(4'b0000, 1'b0);
        ticks(6);
        chk("release_edge6_pulse", RELEASE_PULSE, 4'b0000);
        tick();
        chk("release_edge7_pulse", RELEASE_PULSE, 4'b0001);
        chk("release_edge7_press", PRESS_PULSE, 4'b0000);
        chk("release_edge7_level", DB_LEVEL, 4'b0000);

        // Simultaneous press on ch0 and ch3
        drive(4'b1001, 1'b0);
        ticks(7);
        chk("simul_press", PRESS_PULSE, 4'b1001);
        drive(4'b0000, 1'b0);
        ticks(10);

        // Reset in the middle of a rise check while ch2 stays high
        drive(4'b0100, 1'b0);
        ticks(5);
        drive(4'b0100, 1'b1);
        ticks(2);
        chk("midreset_level", DB_LEVEL, 4'b0000);
        chk("midreset_press", PRESS_PULSE, 4'b0000);
        drive(4'b0100, 1'b0);
        ticks(6);
        chk("postreset_edge6_level", DB_LEVEL, 4'b0000);
        tick();
        chk("postreset_edge7_press", PRESS_PULSE, 4'b0100);
        chk("postreset_edge7_level", DB_LEVEL, 4'b0100);

        // Hold ch2 for 30 cycles past acceptance
        npress = int'(PRESS_PULSE[2]);
        for (int i = 0; i < 30; i++) begin
            tick();
            npress += int'(PRESS_PULSE[2]);
        end
        chk_int("hold_press_count", npress, REP_EN ? 6 : 1);
        drive(4'b0000, 1'b0);
        ticks(12);

        // Randomized bouncy inputs with rare resets
        for (int c = 0; c < NCH; c++) hold[c] = 0;
        v = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold[c] == 0) begin
                    v[c]    = $urandom_range(0, 1);
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 40)
                                                          : $urandom_range(1, 7);
                end
                hold[c]--;
            end
            drive(v, $urandom_range(0, 399) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
